// File: rtl/tl_scratchpad_responder.sv
// TileLink-UL manager terminating one A/D pair in a single-ported 64-bit scratchpad.
// One registered response slot; one-cycle latency from A fire to D valid.
module tl_scratchpad_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 512
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [5:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [5:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);
    localparam int          IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WINDOW_BYTES = 32'(8 * DEPTH_WORDS);

    logic [63:0] mem [DEPTH_WORDS];
    logic [63:0] rd_data_reg;

    logic        d_valid_reg;
    logic [2:0]  d_opcode_reg;
    logic [2:0]  d_size_reg;
    logic [5:0]  d_source_reg;
    logic        d_denied_reg;
    logic        d_corrupt_reg;
    logic        data_sel_reg;

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             is_put;
    logic             is_get;
    logic             is_hint;
    logic             is_atomic;
    logic             size_ok;
    logic             denied;
    logic             a_fire;
    logic             d_fire;
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       d_opcode_next;
    logic             d_corrupt_next;

    // Subtraction wraps for addresses below the base, so one compare covers both bounds.
    assign offset   = auto_in_a_bits_address - BASE_ADDR;
    assign idx      = offset[IDX_W+2:3];
    assign in_range = offset < WINDOW_BYTES;

    assign is_put    = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
    assign is_atomic = (auto_in_a_bits_opcode == 3'd2) || (auto_in_a_bits_opcode == 3'd3);
    assign is_get    = (auto_in_a_bits_opcode == 3'd4);
    assign is_hint   = (auto_in_a_bits_opcode == 3'd5);
    assign size_ok   = auto_in_a_bits_size <= 3'd3;

    // Hints never touch memory, so only the window check applies to them.
    assign denied = !in_range || (!is_hint && (!size_ok || !(is_put || is_get)));

    assign auto_in_a_ready = !d_valid_reg || auto_in_d_ready;
    assign a_fire          = auto_in_a_valid && auto_in_a_ready && !reset;
    assign d_fire          = d_valid_reg && auto_in_d_ready;
    assign wr_en           = a_fire && is_put && !denied;
    assign rd_en           = a_fire && is_get && !denied;

    always_comb begin
        d_opcode_next = 3'd0;
        if (is_get || is_atomic) begin
            d_opcode_next = 3'd1;
        end else if (is_hint) begin
            d_opcode_next = 3'd2;
        end
        d_corrupt_next = denied && (is_get || is_atomic);
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_a_bits_mask[b]) begin
                    mem[idx][b*8 +: 8] <= auto_in_a_bits_data[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_reg <= mem[idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid_reg   <= 1'b0;
            d_opcode_reg  <= 3'd0;
            d_size_reg    <= 3'd0;
            d_source_reg  <= 6'd0;
            d_denied_reg  <= 1'b0;
            d_corrupt_reg <= 1'b0;
            data_sel_reg  <= 1'b0;
        end else if (a_fire) begin
            d_valid_reg   <= 1'b1;
            d_opcode_reg  <= d_opcode_next;
            d_size_reg    <= auto_in_a_bits_size;
            d_source_reg  <= auto_in_a_bits_source;
            d_denied_reg  <= denied;
            d_corrupt_reg <= d_corrupt_next;
            data_sel_reg  <= is_get && !denied;
        end else if (d_fire) begin
            d_valid_reg <= 1'b0;
        end
    end

    // RAM output register is not reset; the select flag forces zero data until a good Get.
    assign auto_in_d_valid        = d_valid_reg;
    assign auto_in_d_bits_opcode  = d_opcode_reg;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = d_size_reg;
    assign auto_in_d_bits_source  = d_source_reg;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = d_denied_reg;
    assign auto_in_d_bits_data    = data_sel_reg ? rd_data_reg : 64'd0;
    assign auto_in_d_bits_corrupt = d_corrupt_reg;

    logic unused_inputs;
    assign unused_inputs = ^{auto_in_a_bits_param, auto_in_a_bits_corrupt,
                             offset[2:0], offset[31:IDX_W+3]};
endmodule

// File: tb/tb_tl_scratchpad_responder.sv
// Directed and randomized checks of tl_scratchpad_responder against a byte-level memory model.
module tb_tl_scratchpad_responder;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 512;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [5:0]  src;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
    } req_t;

    typedef struct {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [5:0]  source;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [5:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;
    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [5:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    int errors = 0;
    int checks = 0;
    logic [63:0] ref_mem [DEPTH];

    tl_scratchpad_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Reference behaviour: window/size/opcode rules applied to a plain word array.
    task automatic model(input req_t r, output resp_t e);
        longint unsigned a;
        bit in_range;
        bit bad_size;
        int idx;
        a        = longint'(r.addr);
        in_range = (a >= longint'(BASE)) && (a < longint'(BASE) + 8 * DEPTH);
        idx      = in_range ? int'((a - longint'(BASE)) / 8) : 0;
        bad_size = r.size > 3;
        e.size = r.size;
        e.source = r.src;
        e.data = 64'd0;
        e.corrupt = 1'b0;
        case (r.op)
            3'd4: begin
                e.opcode = 3'd1;
                e.denied = !in_range || bad_size;
                if (e.denied) e.corrupt = 1'b1;
                else e.data = ref_mem[idx];
            end
            3'd0, 3'd1: begin
                e.opcode = 3'd0;
                e.denied = !in_range || bad_size;
                if (!e.denied) begin
                    for (int b = 0; b < 8; b++)
                        if (r.mask[b]) ref_mem[idx][b*8 +: 8] = r.data[b*8 +: 8];
                end
            end
            3'd5: begin
                e.opcode = 3'd2;
                e.denied = !in_range;
            end
            3'd2, 3'd3: begin
                e.opcode = 3'd1;
                e.denied = 1'b1;
                e.corrupt = 1'b1;
            end
            default: begin
                e.opcode = 3'd0;
                e.denied = 1'b1;
            end
        endcase
    endtask

    task automatic drive(input req_t r);
        a_valid   = 1'b1;
        a_opcode  = r.op;
        a_param   = 3'($urandom_range(0, 7));
        a_size    = r.size;
        a_source  = r.src;
        a_address = r.addr;
        a_mask    = r.mask;
        a_data    = r.data;
        a_corrupt = 1'($urandom_range(0, 1));
    endtask

    // Present a request, wait for a_ready (bounded), let it fire, then model it.
    task automatic issue(input req_t r, output resp_t e);
        int n;
        drive(r);
        n = 0;
        while (a_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("a_ready_wait", 64'(n < 20), 64'd1);
        @(posedge clock); #1;
        model(r, e);
    endtask

    task automatic check_resp(input string tag, input resp_t e);
        chk({tag, ".d_valid"}, 64'(d_valid), 64'd1);
        chk({tag, ".opcode"}, 64'(d_opcode), 64'(e.opcode));
        chk({tag, ".size"}, 64'(d_size), 64'(e.size));
        chk({tag, ".source"}, 64'(d_source), 64'(e.source));
        chk({tag, ".denied"}, 64'(d_denied), 64'(e.denied));
        chk({tag, ".corrupt"}, 64'(d_corrupt), 64'(e.corrupt));
        chk({tag, ".param_sink"}, 64'({d_param, d_sink}), 64'd0);
        if (e.opcode == 3'd1) chk({tag, ".data"}, d_data, e.data);
    endtask

    function automatic req_t mk(input logic [2:0] op, input logic [2:0] size, input logic [5:0] src,
                                input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
        req_t r;
        r.op = op; r.size = size; r.src = src; r.addr = addr; r.mask = mask; r.data = data;
        return r;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 4))
            0: a = BASE + 32'(8 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 7));
            1: a = BASE + 32'(8 * DEPTH) + 32'($urandom_range(0, 15));
            2: a = BASE - 32'($urandom_range(1, 16));
            3: a = $urandom;
            default: a = BASE + 32'(8 * DEPTH - 8) + 32'($urandom_range(0, 7));
        endcase
        return a;
    endfunction

    initial begin
        req_t  r, r2;
        resp_t e, e2;

        reset = 1'b1; d_ready = 1'b1;
        drive(mk(3'd0, 3'd3, 6'd0, BASE, 8'hFF, 64'd0));
        a_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("reset.d_valid", 64'(d_valid), 64'd0);
        chk("reset.a_ready", 64'(a_ready), 64'd1);
        chk("reset.d_fields", {d_data[31:0] | d_data[63:32], 8'd0, d_opcode, d_param, d_size, d_source,
                               d_sink, d_denied, d_corrupt}, 64'd0);
        @(posedge clock); #1;

        // Fill the whole window so every later read has a known expected value.
        for (int i = 0; i < DEPTH; i++) begin
            issue(mk(3'd0, 3'd3, 6'(i), BASE + 32'(8 * i), 8'hFF, {$urandom, $urandom}), e);
            check_resp($sformatf("init%0d", i), e);
        end
        a_valid = 1'b0;
        @(posedge clock); #1;
        chk("idle.d_valid", 64'(d_valid), 64'd0);

        issue(mk(3'd0, 3'd3, 6'd5, 32'h1000_0008, 8'hFF, 64'h1122334455667788), e);
        check_resp("putfull", e);
        chk("putfull.expect_tbl", 64'({e.opcode, e.denied}), 64'({3'd0, 1'b0}));
        issue(mk(3'd4, 3'd3, 6'd6, 32'h1000_0008, 8'hFF, 64'd0), e);
        check_resp("get_after_put", e);
        chk("get_after_put.tbl", d_data, 64'h1122334455667788);
        issue(mk(3'd1, 3'd3, 6'd7, 32'h1000_0008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB), e);
        check_resp("putpartial", e);
        issue(mk(3'd4, 3'd3, 6'd8, 32'h1000_000F, 8'h00, 64'd0), e);
        check_resp("get_partial", e);
        chk("get_partial.tbl", d_data, 64'h11223344_BBBBBBBB);
        issue(mk(3'd0, 3'd3, 6'd9, 32'h1000_1000, 8'hFF, 64'hDEAD), e);
        check_resp("put_oor_hi", e);
        issue(mk(3'd4, 3'd3, 6'd10, 32'h1000_1000, 8'hFF, 64'd0), e);
        check_resp("get_oor_hi", e);
        chk("get_oor_hi.data", d_data, 64'd0);
        issue(mk(3'd0, 3'd3, 6'd11, 32'h0FFF_FFF8, 8'hFF, 64'hBEEF), e);
        check_resp("put_oor_lo", e);
        issue(mk(3'd4, 3'd3, 6'd12, 32'h1000_0FF8, 8'hFF, 64'd0), e);
        check_resp("get_last_word", e);
        issue(mk(3'd4, 3'd3, 6'd13, 32'h1000_0000, 8'hFF, 64'd0), e);
        check_resp("get_first_word", e);
        issue(mk(3'd2, 3'd3, 6'd14, 32'h1000_0010, 8'hFF, 64'd1), e);
        check_resp("arith", e);
        issue(mk(3'd5, 3'd2, 6'd15, 32'h1000_0020, 8'hFF, 64'd0), e);
        check_resp("hint", e);
        issue(mk(3'd4, 3'd4, 6'd16, 32'h1000_0020, 8'hFF, 64'd0), e);
        check_resp("get_size4", e);

        // Backpressure: a held Get response blocks a pending Put until D drains.
        issue(mk(3'd4, 3'd3, 6'd20, 32'h1000_0040, 8'hFF, 64'd0), e);
        check_resp("bp.first", e);
        d_ready = 1'b0;
        r2 = mk(3'd0, 3'd3, 6'd21, 32'h1000_0040, 8'hFF, 64'hCAFE_F00D_1234_5678);
        drive(r2);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp.a_ready%0d", c), 64'(a_ready), 64'd0);
            check_resp($sformatf("bp.hold%0d", c), e);
            @(posedge clock); #1;
        end
        d_ready = 1'b1;
        #1 chk("bp.a_ready_release", 64'(a_ready), 64'd1);
        @(posedge clock); #1;
        model(r2, e2);
        check_resp("bp.second", e2);
        a_valid = 1'b0;
        @(posedge clock); #1;
        chk("bp.drained", 64'(d_valid), 64'd0);
        issue(mk(3'd4, 3'd3, 6'd22, 32'h1000_0040, 8'hFF, 64'd0), e);
        check_resp("bp.readback", e);

        // Streaming: each iteration is exactly one cycle, so beats are back-to-back.
        for (int i = 0; i < 16; i++) begin
            issue(mk(3'd4, 3'd3, 6'(32 + i), BASE + 32'(8 * $urandom_range(0, DEPTH - 1)), 8'hFF, 64'd0), e);
            check_resp($sformatf("stream%0d", i), e);
        end
        a_valid = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 300; i++) begin
            r.op   = 3'($urandom_range(0, 7));
            r.size = (r.op == 3'd5) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 4));
            r.src  = 6'($urandom);
            r.addr = pick_addr();
            r.mask = 8'($urandom);
            r.data = {$urandom, $urandom};
            issue(r, e);
            check_resp($sformatf("rand%0d_op%0d", i, r.op), e);
            if ($urandom_range(0, 3) == 0) begin
                a_valid = 1'b0;
                @(posedge clock); #1;
                chk($sformatf("rand%0d.gap", i), 64'(d_valid), 64'd0);
            end
        end

        // Reset with a held response and a pending Put: response dropped, write suppressed.
        issue(mk(3'd4, 3'd3, 6'd40, 32'h1000_0100, 8'hFF, 64'd0), e);
        check_resp("rst.before", e);
        d_ready = 1'b0;
        reset = 1'b1;
        drive(mk(3'd0, 3'd3, 6'd41, 32'h1000_0100, 8'hFF, 64'h5555_6666_7777_8888));
        @(posedge clock); #1;
        chk("rst.d_valid", 64'(d_valid), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        a_valid = 1'b0;
        d_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("rst.no_stale%0d", c), 64'({d_valid, d_data}), 64'd0);
            @(posedge clock); #1;
        end
        issue(mk(3'd4, 3'd3, 6'd42, 32'h1000_0100, 8'hFF, 64'd0), e);
        check_resp("rst.no_write", e);
        a_valid = 1'b0;
        @(posedge clock); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
